// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer-phase state encoding, default bus widths
// and the meaning of each Prot bit.
//   APB_ADDR_W / APB_DATA_W : default address / data widths of the link
//   PROT_W                  : width of the protection attribute
//   PROT_*_BIT              : bit positions inside Prot
//   apb_state_t             : IDLE / SETUP / ACCESS transfer phases
package apb_pkg;

    localparam int APB_ADDR_W = 5;
    localparam int APB_DATA_W = 32;
    localparam int PROT_W     = 3;

    localparam int PROT_PRIV_BIT   = 0;  // 1 = privileged access
    localparam int PROT_NONSEC_BIT = 1;  // 1 = non-secure access
    localparam int PROT_INSTR_BIT  = 2;  // 1 = instruction fetch

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_master_if.sv
// Bundle of the command, response and APB signals around apb_master.
//   command  : cmd_valid/cmd_ready handshake, cmd_write, cmd_addr, cmd_wdata, cmd_prot
//   response : rsp_valid pulse, rsp_rdata, rsp_err, rsp_timeout
//   APB      : psel, penable, pwrite, addr, Prot, pwdata, pready, pslverr, prdata
// Modport master is the apb_master view; modport slave is the view of
// whatever sits on the other side (control logic plus APB slave).
interface apb_master_if #(
    parameter int ADDR_W = apb_pkg::APB_ADDR_W,
    parameter int DATA_W = apb_pkg::APB_DATA_W
);

    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_write;
    logic [ADDR_W-1:0]          cmd_addr;
    logic [DATA_W-1:0]          cmd_wdata;
    logic [apb_pkg::PROT_W-1:0] cmd_prot;

    logic                       rsp_valid;
    logic [DATA_W-1:0]          rsp_rdata;
    logic                       rsp_err;
    logic                       rsp_timeout;

    logic                       psel;
    logic                       penable;
    logic                       pwrite;
    logic [ADDR_W-1:0]          addr;
    logic [apb_pkg::PROT_W-1:0] Prot;
    logic [DATA_W-1:0]          pwdata;
    logic                       pready;
    logic                       pslverr;
    logic [DATA_W-1:0]          prdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, pwrite, addr, Prot, pwdata,
        input  pready, pslverr, prdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, pwrite, addr, Prot, pwdata,
        output pready, pslverr, prdata
    );

endinterface

// File: rtl/apb_wait_timer.sv
// Saturating wait-state watchdog counter.
//   clk, resetn : clock, asynchronous active-low reset
//   clear       : reset the count to zero (has priority over enable)
//   enable      : count one more wait cycle
//   expired     : count has reached TIMEOUT-1
// The counter is one bit wider than strictly needed and stops at all-ones,
// so a stray enable after expiry can never wrap it back to a small value.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count_reg != '1)) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expired = (count_reg == LAST);

endmodule

// File: rtl/apb_master.sv
// APB initiator: turns single-beat command-port requests into APB
// SETUP/ACCESS sequences, honours pready wait states, and reports read data
// and error status on the response port. A watchdog aborts a transfer after
// TIMEOUT ACCESS cycles without pready.
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : apb_master_if.master (command, response and APB signals)
// Parameters: ADDR_W, DATA_W (bus widths), TIMEOUT (>= 2, ACCESS-cycle limit).
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         resetn,
    apb_master_if.master bus
);

    apb_state_t          state_reg;
    logic                psel_reg;
    logic                penable_reg;
    logic                pwrite_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [PROT_W-1:0]   prot_reg;
    logic [DATA_W-1:0]   pwdata_reg;
    logic                rsp_valid_reg;
    logic [DATA_W-1:0]   rsp_rdata_reg;
    logic                rsp_err_reg;
    logic                rsp_timeout_reg;

    logic                timer_clear;
    logic                timer_enable;
    logic                timer_expired;

    // The count is zero in the first ACCESS cycle, so expiry at TIMEOUT-1
    // lands on exactly the TIMEOUT-th ACCESS cycle.
    assign timer_clear  = (state_reg == SETUP);
    assign timer_enable = (state_reg == ACCESS) && !bus.pready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= IDLE;
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            pwrite_reg      <= 1'b0;
            addr_reg        <= '0;
            prot_reg        <= '0;
            pwdata_reg      <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        pwrite_reg <= bus.cmd_write;
                        addr_reg   <= bus.cmd_addr;
                        pwdata_reg <= bus.cmd_wdata;
                        prot_reg   <= bus.cmd_prot;
                        psel_reg   <= 1'b1;
                        state_reg  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_reg <= 1'b1;
                    state_reg   <= ACCESS;
                end
                ACCESS: begin
                    if (bus.pready) begin
                        psel_reg        <= 1'b0;
                        penable_reg     <= 1'b0;
                        state_reg       <= IDLE;
                        rsp_valid_reg   <= 1'b1;
                        rsp_err_reg     <= bus.pslverr;
                        rsp_timeout_reg <= 1'b0;
                        // Read data is only meaningful for a clean read.
                        rsp_rdata_reg   <= (!pwrite_reg && !bus.pslverr) ? bus.prdata : '0;
                    end else if (timer_expired) begin
                        psel_reg        <= 1'b0;
                        penable_reg     <= 1'b0;
                        state_reg       <= IDLE;
                        rsp_valid_reg   <= 1'b1;
                        rsp_err_reg     <= 1'b1;
                        rsp_timeout_reg <= 1'b1;
                        rsp_rdata_reg   <= '0;
                    end
                end
                default: begin
                    psel_reg    <= 1'b0;
                    penable_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = (state_reg == IDLE);
    assign bus.psel        = psel_reg;
    assign bus.penable     = penable_reg;
    assign bus.pwrite      = pwrite_reg;
    assign bus.addr        = addr_reg;
    assign bus.Prot        = prot_reg;
    assign bus.pwdata      = pwdata_reg;
    assign bus.rsp_valid   = rsp_valid_reg;
    assign bus.rsp_rdata   = rsp_rdata_reg;
    assign bus.rsp_err     = rsp_err_reg;
    assign bus.rsp_timeout = rsp_timeout_reg;

endmodule

// File: doc/apb_master.md
# apb_master

Initiator end of the team's APB link: converts single-beat requests from an on-chip command port into APB SETUP/ACCESS sequences on `psel`/`penable`, honours slave wait states via `pready`, and returns read data and error status on a response port. A wait-state watchdog aborts transfers to slaves that never respond. It sits between the control logic and any APB slave using the same 5-bit address, 32-bit data and 3-bit `Prot` conventions.

## Interface
Parameters:
- `ADDR_W`, 5, APB address width
- `DATA_W`, 32, APB data width
- `TIMEOUT`, 16, maximum ACCESS cycles without `pready` before abort (≥2)

Ports:
- `clk`  in  1  sole clock, rising edge
- `resetn`  in  1  reset, asynchronous, active-low
- `cmd_valid`  in  1  request present
- `cmd_ready`  out  1  request accepted when high with `cmd_valid`
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_W  target address
- `cmd_wdata`  in  DATA_W  write data
- `cmd_prot`  in  3  protection attribute, passed to `Prot`
- `rsp_valid`  out  1  one-cycle completion pulse, no backpressure
- `rsp_rdata`  out  DATA_W  read data; 0 for writes, errors, timeouts
- `rsp_err`  out  1  `pslverr` sampled, or timeout
- `rsp_timeout`  out  1  transfer aborted by watchdog
- `psel`, `penable`, `pwrite`  out  1  APB control
- `addr`  out  ADDR_W  APB address
- `Prot`  out  3  APB protection
- `pwdata`  out  DATA_W  APB write data
- `pready`, `pslverr`  in  1  slave handshake/error
- `prdata`  in  DATA_W  slave read data

## Operation
- FSM: IDLE, SETUP, ACCESS. `cmd_ready` = (state == IDLE), combinational.
- IDLE: on `cmd_valid && cmd_ready`, register write/addr/wdata/prot onto `pwrite`/`addr`/`pwdata`/`Prot`; go to SETUP.
- SETUP: `psel`=1, `penable`=0; unconditionally go to ACCESS; clear wait counter.
- ACCESS: `psel`=1, `penable`=1. If `pready`: capture `pslverr`, capture `prdata` (read with `pslverr`=0 only, else 0), go to IDLE, pulse `rsp_valid` the next cycle. Else increment wait counter; when it reaches TIMEOUT−1 with `pready` low, go to IDLE with `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
- No ACCESS→SETUP shortcut: every transfer returns through IDLE.
- `addr`, `pwrite`, `pwdata`, `Prot` stable from SETUP through the last ACCESS cycle; they hold last values in IDLE. `psel`/`penable` are 0 in IDLE.
- `rsp_*` data fields hold until the next completion; `rsp_valid` is high for exactly one cycle.
- Wait counter width is $clog2(TIMEOUT)+1; it saturates, never wraps.

## Timing
- Reset (async): state IDLE; `psel`, `penable`, `pwrite`, `addr`, `Prot`, `pwdata`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `rsp_timeout` all 0. `cmd_valid` is ignored while `resetn` is low.
- Acceptance at edge N: SETUP in cycle N, ACCESS from N+1. With zero-wait slave, `pready` is sampled at edge N+2, and `rsp_valid` and `cmd_ready` are both high in cycle N+2. Throughput is one transfer per 3 cycles; each wait state adds 1 cycle.
- Timeout: `psel`=0 after exactly TIMEOUT ACCESS cycles, then `rsp_valid` the next cycle.
- Reset during SETUP/ACCESS: `psel`/`penable` drop immediately; no `rsp_valid` is issued for the lost transfer.
- `cmd_valid` during SETUP/ACCESS is stalled (`cmd_ready`=0) and not dropped.

## Structure
- Shared package `apb_pkg`: state enum (IDLE/SETUP/ACCESS), default ADDR_W/DATA_W, `Prot` bit indices (0 privileged, 1 non-secure, 2 instruction).
- One sub-module is natural: `apb_wait_timer`, the saturating watchdog counter with clear/enable/expired ports. Everything else is flat.

## Test plan
- Write `cmd_addr`=5'h03, `cmd_wdata`=32'hDEADBEEF, `cmd_prot`=3'b000, zero-wait slave -> `psel` high 2 cycles, `penable` in 2nd only; `rsp_valid` with `rsp_err`=0, `rsp_rdata`=0; `cmd_ready` back 3 cycles after accept.
- Read 5'h03 after the above -> `rsp_rdata`=32'hDEADBEEF, `rsp_err`=0.
- Slave inserts 2 wait states on write to 5'h1F -> ACCESS lasts 3 cycles, `addr`/`pwdata`/`Prot` unchanged throughout, single `rsp_valid`.
- Read with `pslverr`=1, `prdata`=32'h00001234 -> `rsp_err`=1, `rsp_timeout`=0, `rsp_rdata`=0.
- `pready` tied low, TIMEOUT=16 -> `psel` falls after 16 ACCESS cycles; `rsp_err`=1, `rsp_timeout`=1; next command accepted normally.
- `resetn` low during ACCESS -> `psel`/`penable` 0 in the same cycle, no `rsp_valid`; after release, `cmd_ready`=1 and a write completes normally.
